// File: rtl/fib_hash_if.sv
// Request/response bundle between the FIB and the prefix hasher.
// The FIB is the master: it drives the prefix, the length and the request strobe.
interface fib_hash_if;
    logic [63:0] hash_prefix_in;
    logic [5:0]  hash_len_in;
    logic        hash_req;
    logic        hash_ready;
    logic [9:0]  hash;
    logic        hash_valid;

    modport master (
        output hash_prefix_in,
        output hash_len_in,
        output hash_req,
        input  hash_ready,
        input  hash,
        input  hash_valid
    );

    modport slave (
        input  hash_prefix_in,
        input  hash_len_in,
        input  hash_req,
        output hash_ready,
        output hash,
        output hash_valid
    );
endinterface

// File: rtl/fib_hash.sv
// Multi-cycle 10-bit prefix hash: one byte folded into a rotating accumulator per cycle.
// A result takes 8 cycles after acceptance and is announced by a one-cycle hash_valid pulse.
module fib_hash #(
    parameter logic [9:0] HASH_SEED = 10'h2A5
) (
    input logic        clk,
    input logic        rst,
    fib_hash_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StHash, StDone} state_e;

    state_e      state_q;
    logic [63:0] prefix_q;
    logic [5:0]  len_q;
    logic [9:0]  acc_q;
    logic [2:0]  cnt_q;
    logic [9:0]  hash_q;
    logic        hash_valid_q;

    logic [63:0] len_mask;
    logic [63:0] prefix_masked;
    logic [7:0]  cur_byte;
    logic [9:0]  acc_next;

    // Masking the latched copy is equivalent to masking at capture, since neither changes
    // while a hash is in flight; bit 63 is never significant because len tops out at 63.
    always_comb begin
        len_mask      = (64'd1 << len_q) - 64'd1;
        prefix_masked = prefix_q & len_mask;
        cur_byte      = prefix_masked[{cnt_q, 3'b000} +: 8];
        acc_next      = {acc_q[6:0], acc_q[9:7]} ^ {2'b00, cur_byte};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            prefix_q     <= 64'd0;
            len_q        <= 6'd0;
            acc_q        <= 10'd0;
            cnt_q        <= 3'd0;
            hash_q       <= 10'd0;
            hash_valid_q <= 1'b0;
        end else begin
            hash_valid_q <= 1'b0;
            case (state_q)
                StHash: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        hash_q       <= acc_next;
                        hash_valid_q <= 1'b1;
                        state_q      <= StDone;
                    end
                end
                // Idle and Done accept identically; without a request both settle in Idle.
                default: begin
                    if (bus.hash_req) begin
                        prefix_q <= bus.hash_prefix_in;
                        len_q    <= bus.hash_len_in;
                        acc_q    <= HASH_SEED ^ {4'b0000, bus.hash_len_in};
                        cnt_q    <= 3'd0;
                        state_q  <= StHash;
                    end else begin
                        state_q  <= StIdle;
                    end
                end
            endcase
        end
    end

    assign bus.hash       = hash_q;
    assign bus.hash_valid = hash_valid_q;
    assign bus.hash_ready = (state_q == StIdle) || (state_q == StDone);

endmodule
